// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and LSU.
// Serialises requests, routes responses and aborts stalled transactions.
module mem_port_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_inst_req,
    input  logic [DATA_WIDTH-1:0]      i_inst_addr,
    output logic                       o_inst_valid,
    output logic [DATA_WIDTH-1:0]      o_inst_data,
    input  logic                       i_data_req,
    input  logic                       i_data_we,
    input  logic [BYTE_DATA_WIDTH-1:0] i_byte_enable,
    input  logic [DATA_WIDTH-1:0]      i_data_addr,
    input  logic [DATA_WIDTH-1:0]      i_wdata,
    output logic                       o_data_valid,
    output logic [DATA_WIDTH-1:0]      o_rdata,
    output logic                       o_mem_req,
    output logic                       o_mem_we,
    output logic [BYTE_DATA_WIDTH-1:0] o_mem_byte_enable,
    output logic [DATA_WIDTH-1:0]      o_mem_addr,
    output logic [DATA_WIDTH-1:0]      o_mem_wdata,
    input  logic                       i_mem_valid,
    input  logic [DATA_WIDTH-1:0]      i_mem_rdata,
    output logic                       o_bus_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_INST,
        BUSY_DATA,
        RESP
    } state_t;

    state_t                     r_state;
    logic                       r_last_data;
    logic [CW-1:0]              r_cnt;
    logic                       r_mem_req;
    logic                       r_mem_we;
    logic [BYTE_DATA_WIDTH-1:0] r_mem_be;
    logic [DATA_WIDTH-1:0]      r_mem_addr;
    logic [DATA_WIDTH-1:0]      r_mem_wdata;
    logic                       r_inst_valid;
    logic [DATA_WIDTH-1:0]      r_inst_data;
    logic                       r_data_valid;
    logic [DATA_WIDTH-1:0]      r_rdata;
    logic                       r_bus_error;

    logic w_grant_inst;
    logic w_grant_data;
    logic w_timeout;

    // On contention the side that did not win last time gets the port.
    assign w_grant_inst = i_inst_req && (!i_data_req || r_last_data);
    assign w_grant_data = i_data_req && !w_grant_inst;
    assign w_timeout    = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= IDLE;
            r_last_data  <= 1'b1;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_inst_valid <= 1'b0;
            r_inst_data  <= '0;
            r_data_valid <= 1'b0;
            r_rdata      <= '0;
            r_bus_error  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_grant_inst) begin
                        r_state     <= BUSY_INST;
                        r_last_data <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '1;
                        r_mem_addr  <= i_inst_addr;
                        r_mem_wdata <= '0;
                    end else if (w_grant_data) begin
                        r_state     <= BUSY_DATA;
                        r_last_data <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= i_data_we;
                        r_mem_be    <= i_byte_enable;
                        r_mem_addr  <= i_data_addr;
                        r_mem_wdata <= i_wdata;
                    end
                end
                BUSY_INST: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_mem_valid) begin
                        r_inst_data  <= i_mem_rdata;
                        r_inst_valid <= 1'b1;
                        r_bus_error  <= 1'b0;
                        r_mem_req    <= 1'b0;
                        r_state      <= RESP;
                    end else if (w_timeout) begin
                        r_inst_data  <= '0;
                        r_inst_valid <= 1'b1;
                        r_bus_error  <= 1'b1;
                        r_mem_req    <= 1'b0;
                        r_state      <= RESP;
                    end
                end
                BUSY_DATA: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_mem_valid) begin
                        r_rdata      <= i_mem_rdata;
                        r_data_valid <= 1'b1;
                        r_bus_error  <= 1'b0;
                        r_mem_req    <= 1'b0;
                        r_state      <= RESP;
                    end else if (w_timeout) begin
                        r_rdata      <= '0;
                        r_data_valid <= 1'b1;
                        r_bus_error  <= 1'b1;
                        r_mem_req    <= 1'b0;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    r_inst_valid <= 1'b0;
                    r_data_valid <= 1'b0;
                    r_bus_error  <= 1'b0;
                    r_cnt        <= '0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_mem_req         = r_mem_req;
    assign o_mem_we          = r_mem_we;
    assign o_mem_byte_enable = r_mem_be;
    assign o_mem_addr        = r_mem_addr;
    assign o_mem_wdata       = r_mem_wdata;
    assign o_inst_valid      = r_inst_valid;
    assign o_inst_data       = r_inst_data;
    assign o_data_valid      = r_data_valid;
    assign o_rdata           = r_rdata;
    assign o_bus_error       = r_bus_error;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grants and responses are
// queued when stimulus is driven and checked as the DUT produces them.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int TO = 4;

    typedef struct packed {
        logic [DW-1:0] addr;
        logic          we;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
    } gnt_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inst_req = 1'b0;
    logic [DW-1:0] inst_addr = '0;
    logic          inst_valid;
    logic [DW-1:0] inst_data;
    logic          data_req = 1'b0;
    logic          data_we = 1'b0;
    logic [BW-1:0] byte_enable = '0;
    logic [DW-1:0] data_addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          data_valid;
    logic [DW-1:0] rdata;
    logic          mem_req;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          bus_error;

    gnt_t          gq[$];
    rsp_t          iq[$];
    rsp_t          dq[$];
    logic [DW-1:0] ia[$];
    logic [DW-1:0] da[$];

    int   n_vec = 0;
    int   n_bad = 0;
    logic mem_auto = 1'b1;
    logic pulse_tog = 1'b0;
    logic pulse_seen = 1'b0;
    logic prev_req = 1'b0;
    int   req_len = 0;
    int   last_len = 0;
    gnt_t cur;

    mem_port_arbiter #(
        .DATA_WIDTH     (DW),
        .BYTE_DATA_WIDTH(BW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_inst_req       (inst_req),
        .i_inst_addr      (inst_addr),
        .o_inst_valid     (inst_valid),
        .o_inst_data      (inst_data),
        .i_data_req       (data_req),
        .i_data_we        (data_we),
        .i_byte_enable    (byte_enable),
        .i_data_addr      (data_addr),
        .i_wdata          (wdata),
        .o_data_valid     (data_valid),
        .o_rdata          (rdata),
        .o_mem_req        (mem_req),
        .o_mem_we         (mem_we),
        .o_mem_byte_enable(mem_be),
        .o_mem_addr       (mem_addr),
        .o_mem_wdata      (mem_wdata),
        .i_mem_valid      (mem_valid),
        .i_mem_rdata      (mem_rdata),
        .o_bus_error      (bus_error)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
        if (a == 32'h100) return 32'h00A00093;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: answers one cycle after it sees mem_req, or on demand.
    always @(negedge clk) begin
        if (mem_valid) begin
            mem_valid = 1'b0;
        end else if (pulse_tog != pulse_seen) begin
            mem_valid = 1'b1;
            mem_rdata = 32'hFFFF_FFFF;
        end else if (mem_req && mem_auto) begin
            mem_valid = 1'b1;
            mem_rdata = mem_word(mem_addr);
        end
        pulse_seen = pulse_tog;
    end

    always @(negedge clk) begin
        rsp_t r;
        if (mem_req) begin
            if (!prev_req) begin
                req_len = 1;
                if (gq.size() == 0) begin
                    chk("grant_spurious", 64'(gq.size()), 64'd1);
                end else begin
                    cur = gq.pop_front();
                    chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
                    chk("mem_we", 64'(mem_we), 64'(cur.we));
                    chk("mem_be", 64'(mem_be), 64'(cur.be));
                    chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
                end
            end else begin
                req_len++;
                chk("mem_stable", {27'd0, mem_we, mem_be, mem_addr},
                    {27'd0, cur.we, cur.be, cur.addr});
            end
        end else if (prev_req) begin
            last_len = req_len;
        end
        prev_req = mem_req;
        if (inst_valid && data_valid)
            chk("both_valid", 64'(data_valid), 64'd0);
        if (inst_valid) begin
            if (iq.size() == 0) begin
                chk("inst_spurious", 64'(iq.size()), 64'd1);
            end else begin
                r = iq.pop_front();
                chk("inst_data", 64'(inst_data), 64'(r.data));
                chk("inst_err", 64'(bus_error), 64'(r.err));
            end
        end
        if (data_valid) begin
            if (dq.size() == 0) begin
                chk("data_spurious", 64'(dq.size()), 64'd1);
            end else begin
                r = dq.pop_front();
                chk("rdata", 64'(rdata), 64'(r.data));
                chk("data_err", 64'(bus_error), 64'(r.err));
            end
        end
    end

    // Requesters: on completion either present the next address or drop req.
    task automatic drain(input int maxc);
        int n = 0;
        while ((gq.size() != 0 || iq.size() != 0 || dq.size() != 0 ||
                inst_req || data_req) && n < maxc) begin
            @(negedge clk);
            n++;
            if (inst_valid) begin
                if (ia.size() != 0) inst_addr = ia.pop_front();
                else inst_req = 1'b0;
            end
            if (data_valid) begin
                if (da.size() != 0) data_addr = da.pop_front();
                else data_req = 1'b0;
            end
        end
        if (n >= maxc) chk("drain_timeout", 64'(n), 64'(maxc - 1));
        @(negedge clk);
    endtask

    task automatic fetch(input logic [DW-1:0] a);
        gq.push_back('{addr: a, we: 1'b0, be: 4'hF, wdata: '0});
        iq.push_back('{data: mem_word(a), err: 1'b0});
        inst_addr = a;
        inst_req  = 1'b1;
        drain(40);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ctl"}, {56'd0, mem_req, mem_we, mem_be, inst_valid,
            data_valid}, 64'd0);
        chk({tag, "_err"}, 64'(bus_error), 64'd0);
        chk({tag, "_maddr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mwdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_idata"}, 64'(inst_data), 64'd0);
        chk({tag, "_rdata"}, 64'(rdata), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_reset_outs("reset");

        fetch(32'h100);

        gq.push_back('{addr: 32'h2004, we: 1'b1, be: 4'b0011,
                       wdata: 32'hDEADBEEF});
        dq.push_back('{data: mem_word(32'h2004), err: 1'b0});
        data_we     = 1'b1;
        byte_enable = 4'b0011;
        data_addr   = 32'h2004;
        wdata       = 32'hDEADBEEF;
        data_req    = 1'b1;
        drain(40);
        chk("inst_data_hold", 64'(inst_data), 64'h00A00093);

        // Both sides held from reset: grants must alternate, fetch first.
        rst         = 1'b0;
        data_we     = 1'b0;
        byte_enable = 4'hF;
        wdata       = 32'h11112222;
        for (int k = 0; k < 3; k++) begin
            logic [DW-1:0] a_i;
            logic [DW-1:0] a_d;
            a_i = 32'h1000 + 32'(4 * k);
            a_d = 32'h5000 + 32'(16 * k);
            gq.push_back('{addr: a_i, we: 1'b0, be: 4'hF, wdata: '0});
            gq.push_back('{addr: a_d, we: 1'b0, be: 4'hF,
                           wdata: 32'h11112222});
            iq.push_back('{data: mem_word(a_i), err: 1'b0});
            dq.push_back('{data: mem_word(a_d), err: 1'b0});
            if (k > 0) begin
                ia.push_back(a_i);
                da.push_back(a_d);
            end
        end
        inst_addr = 32'h1000;
        data_addr = 32'h5000;
        inst_req  = 1'b1;
        data_req  = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        drain(100);

        // Memory never answers: abort after TO cycles with bus_error.
        mem_auto  = 1'b0;
        data_addr = 32'h3000;
        gq.push_back('{addr: 32'h3000, we: 1'b0, be: 4'hF,
                       wdata: 32'h11112222});
        dq.push_back('{data: '0, err: 1'b1});
        data_req = 1'b1;
        drain(40);
        @(negedge clk);
        chk("timeout_len", 64'(last_len), 64'(TO));
        chk("timeout_rdata", 64'(rdata), 64'd0);
        mem_auto = 1'b1;
        fetch(32'h140);

        // Reset in the middle of a fetch: aborted silently.
        mem_auto  = 1'b0;
        inst_addr = 32'h400;
        gq.push_back('{addr: 32'h400, we: 1'b0, be: 4'hF, wdata: '0});
        inst_req = 1'b1;
        begin
            int n = 0;
            while (!mem_req && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (n >= 10) chk("rst_wait_req", 64'(mem_req), 64'd1);
        end
        @(negedge clk);
        rst      = 1'b0;
        inst_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_outs("midrst");
        pulse_tog = ~pulse_tog;
        repeat (4) @(negedge clk);
        chk("midrst_memreq", 64'(mem_req), 64'd0);
        chk("midrst_idata", 64'(inst_data), 64'd0);
        mem_auto = 1'b1;

        // Stray mem_valid while idle must be ignored.
        fetch(32'h100);
        pulse_tog = ~pulse_tog;
        repeat (4) @(negedge clk);
        chk("idle_pulse_idata", 64'(inst_data), 64'h00A00093);
        chk("idle_pulse_memreq", 64'(mem_req), 64'd0);
        fetch(32'h180);

        chk("queues_empty", 64'(gq.size() + iq.size() + dq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one external memory port between the core's instruction-fetch interface and the LSU data interface. Each requester sees an independent req/valid handshake; the block serialises them onto a single memory bus. It sits between the core boundary and the unified memory/cache, and implements round-robin arbitration, request latching, response routing and a per-transaction timeout.

Parameters:
DATA_WIDTH, 32, width of addresses and data words
BYTE_DATA_WIDTH, 4, number of byte-enable bits (DATA_WIDTH/8)
TIMEOUT_CYCLES, 255, maximum BUSY cycles waiting for mem_valid before the transaction is aborted; must be at least 1; counter width is clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-low
inst_req  in  1  fetch request, level, held until inst_valid
inst_addr  in  DATA_WIDTH  fetch address
inst_valid  out  1  one-cycle fetch completion pulse
inst_data  out  DATA_WIDTH  fetched word, valid while inst_valid=1
data_req  in  1  LSU request, level, held until data_valid
data_we  in  1  1=write, 0=read
byte_enable  in  BYTE_DATA_WIDTH  LSU byte lanes
data_addr  in  DATA_WIDTH  LSU address
wdata  in  DATA_WIDTH  LSU write data
data_valid  out  1  one-cycle LSU completion pulse
rdata  out  DATA_WIDTH  LSU read data, valid while data_valid=1
mem_req  out  1  memory request, held high until mem_valid or timeout
mem_we  out  1  memory write enable
mem_byte_enable  out  BYTE_DATA_WIDTH  memory byte lanes
mem_addr  out  DATA_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_valid  in  1  memory completion, one cycle
mem_rdata  in  DATA_WIDTH  memory read data, sampled when mem_valid=1
bus_error  out  1  pulses together with inst_valid/data_valid when the transaction timed out

Behaviour:
- One clock; reset is synchronous and active-low (rst=0 sampled on a clk rising edge).
- Reset: state=IDLE, last_grant=DATA, timeout counter=0. All outputs are 0: mem_req, mem_we, mem_byte_enable, mem_addr, mem_wdata, inst_valid, data_valid, inst_data, rdata, bus_error.
- Reset asserted mid-transaction aborts it. No valid pulse is issued; mem_req drops on the next edge.
- All outputs are registered.
- FSM states: IDLE, BUSY_INST, BUSY_DATA, RESP.
- IDLE:
  - Only inst_req=1: go to BUSY_INST.
  - Only data_req=1: go to BUSY_DATA.
  - Both: grant the requester not equal to last_grant, then update last_grant.
  - On grant, latch address, we, byte_enable and wdata into the mem_* registers and set mem_req=1.
  - Instruction grants drive mem_we=0, mem_byte_enable all ones, mem_wdata=0.
- BUSY_x: mem_* outputs stay stable; counter increments each cycle.
  - mem_valid=1: latch mem_rdata into inst_data (BUSY_INST) or rdata (BUSY_DATA). Set the matching valid=1, bus_error=0, mem_req=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES with mem_valid=0: set the matching valid=1, bus_error=1, its data output=0, mem_req=0, go to RESP.
  - mem_valid has priority over timeout when both occur in the same cycle.
- RESP: valid and bus_error high for exactly this one cycle. Data output holds its value until the next completion for that requester. Counter clears. Next state is always IDLE.
- Requesters must drop req on the edge that ends RESP. A req still high in IDLE starts a new transaction.
- Request deasserted during BUSY: the transaction still completes and the valid pulse is still issued.
- mem_valid in IDLE or RESP is ignored.
- Request inputs are not sampled outside IDLE.
- Minimum occupancy: 3 cycles (IDLE grant, BUSY with immediate mem_valid, RESP). Earliest valid arrives 2 cycles after the req is sampled.
- Data write: mem_we=1; rdata is still loaded from mem_rdata, and its value is don't-care for the LSU.

Test Plan:
- After reset, inst_req=1, inst_addr=0x100; memory answers mem_valid with 0x00A00093 one cycle after mem_req -> mem_addr=0x100, mem_we=0, mem_byte_enable=4'hF; inst_valid=1 for one cycle with inst_data=0x00A00093; bus_error=0.
- data_req=1, data_we=1, data_addr=0x2004, byte_enable=4'b0011, wdata=0xDEADBEEF -> mem_we=1, mem_byte_enable=4'b0011, mem_addr=0x2004, mem_wdata=0xDEADBEEF; data_valid pulses once; inst_valid stays 0.
- inst_req and data_req both held high from reset, three transactions each -> grant order INST, DATA, INST, DATA, INST, DATA; never two consecutive grants to one side while the other waits.
- TIMEOUT_CYCLES=4, data read, mem_valid never asserted -> mem_req high exactly 4 cycles; data_valid=1 and bus_error=1 in the same cycle; rdata=0; FSM returns to IDLE.
- rst=0 for one cycle while in BUSY_INST -> next cycle all outputs 0; no inst_valid pulse; a later mem_valid is ignored.
- mem_valid pulsed while IDLE with no requests -> no valid outputs and no state change; a later inst fetch completes normally.
